// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // A step counter needs at least one bit even for the narrowest operand.
  function automatic int cnt_w(input int width);
    return (clog2(width) < 1) ? 1 : clog2(width);
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth step: conditional add/subtract of the multiplicand,
// then an arithmetic right shift of the {acc_hi, acc_lo} pair.
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0]   acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic             e,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   acc_hi_nxt,
  output logic [WIDTH-1:0] acc_lo_nxt,
  output logic             e_nxt
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = acc_hi;
    case ({acc_lo[0], e})
      2'b10:   sum = acc_hi - m;
      2'b01:   sum = acc_hi + m;
      default: sum = acc_hi;
    endcase
    // Sign of the WIDTH+1 bit partial sum is replicated into the top.
    acc_hi_nxt = {sum[WIDTH], sum[WIDTH:1]};
    acc_lo_nxt = {sum[0], acc_lo[WIDTH-1:1]};
    e_nxt      = acc_lo[0];
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative signed Booth multiplier: accept a pair in IDLE, retire one step
// per clock in RUN, hold the product in DONE until the consumer takes it.
module booth_mul_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic               busy
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH:0]   m;
  logic [WIDTH:0]   acc_hi, acc_hi_nxt;
  logic [WIDTH-1:0] acc_lo, acc_lo_nxt;
  logic             e, e_nxt;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last;

  assign accept = in_valid && (state == IDLE);
  assign last   = (cnt == CW'(WIDTH - 1));

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc_hi     (acc_hi),
    .acc_lo     (acc_lo),
    .e          (e),
    .m          (m),
    .acc_hi_nxt (acc_hi_nxt),
    .acc_lo_nxt (acc_lo_nxt),
    .e_nxt      (e_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Outputs decode registered state only; no input reaches an output.
  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    out_product = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid   = 1'b1;
        out_product = {acc_hi[WIDTH-1:0], acc_lo};
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m      <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      e      <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      // Extra multiplicand bit keeps -M representable for the most-negative b.
      m      <= {in_b[WIDTH-1], in_b};
      acc_hi <= '0;
      acc_lo <= in_a;
      e      <= 1'b0;
      cnt    <= '0;
    end else if (state == RUN) begin
      acc_hi <= acc_hi_nxt;
      acc_lo <= acc_lo_nxt;
      e      <= e_nxt;
      cnt    <= cnt + CW'(1);
    end
  end

endmodule
